// File: rtl/rf_pkg.sv
// Shared types and default geometry for the multi-port integer register file.
// The core and the testbench both import this package.
package rf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } rf_state_e;

    localparam int unsigned RF_XLEN    = 32;
    localparam int unsigned RF_NREG    = 32;
    localparam int unsigned RF_NRD     = 2;
    localparam int unsigned RF_NWR     = 1;
    localparam int unsigned RF_SP_IDX  = 2;
    localparam logic [31:0] RF_SP_INIT = 32'h0000_0500;

endpackage

// File: rtl/rf_init_seq.sv
// Reset-clear sequencer: walks every register index once after reset, one per cycle,
// so the array can be cleared without a parallel reset on the storage.
module rf_init_seq
    import rf_pkg::*;
#(
    parameter int unsigned      XLEN    = RF_XLEN,
    parameter int unsigned      NREG    = RF_NREG,
    parameter int unsigned      AW      = $clog2(NREG),
    parameter int unsigned      SP_IDX  = RF_SP_IDX,
    parameter logic [XLEN-1:0]  SP_INIT = RF_SP_INIT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            busy_o,
    output logic            sweep_we_o,
    output logic [AW-1:0]   sweep_addr_o,
    output logic [XLEN-1:0] sweep_data_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0] SP_ADDR  = AW'(SP_IDX);

    rf_state_e       state_q;
    logic [AW-1:0]   idx_q;
    logic            busy_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            idx_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Holding rst keeps the sweep parked at index 0 without writing.
    assign sweep_we_o   = (state_q == INIT) && !rst_i;
    assign sweep_addr_o = idx_q;
    assign sweep_data_o = (idx_q == SP_ADDR) ? SP_INIT : '0;
    assign busy_o       = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file with same-cycle write-to-read bypass,
// write-port priority (highest index wins) and a sequential reset-clear sweep.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned      XLEN    = RF_XLEN,
    parameter int unsigned      NREG    = RF_NREG,
    parameter int unsigned      AW      = $clog2(NREG),
    parameter int unsigned      NRD     = RF_NRD,
    parameter int unsigned      NWR     = RF_NWR,
    parameter int unsigned      SP_IDX  = RF_SP_IDX,
    parameter logic [XLEN-1:0]  SP_INIT = RF_SP_INIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    output logic                 init_busy
);

    logic [XLEN-1:0] mem_q [NREG];

    logic            sweep_we;
    logic [AW-1:0]   sweep_addr;
    logic [XLEN-1:0] sweep_data;
    logic [NWR-1:0]  wr_act;

    rf_init_seq #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .AW      (AW),
        .SP_IDX  (SP_IDX),
        .SP_INIT (SP_INIT)
    ) u_init_seq (
        .clk_i        (clk),
        .rst_i        (rst),
        .busy_o       (init_busy),
        .sweep_we_o   (sweep_we),
        .sweep_addr_o (sweep_addr),
        .sweep_data_o (sweep_data)
    );

    // A user write is architectural only outside the sweep and never to x0.
    for (genvar w = 0; w < NWR; w++) begin : g_wr
        assign wr_act[w] = wr_en[w] && !init_busy && (wr_addr[w*AW +: AW] != '0);
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[sweep_addr] <= sweep_data;
        end else begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_act[w]) begin
                    mem_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;

        assign ra = rd_addr[p*AW +: AW];

        always_comb begin
            rv = mem_q[ra];
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_act[w] && (wr_addr[w*AW +: AW] == ra)) begin
                    rv = wr_data[w*XLEN +: XLEN];
                end
            end
            if (init_busy || (ra == '0)) begin
                rv = '0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = rv;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (2 read ports, 2 write ports): directed vector
// table, hand-written reset sequences and randomized traffic against an array model.
module tb_reg_file_mp;
    import rf_pkg::*;

    localparam int unsigned NRD = 2;
    localparam int unsigned NWR = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NRD*5-1:0]  rd_addr;
    logic [NRD*32-1:0] rd_data;
    logic [NWR-1:0]    wr_en;
    logic [NWR*5-1:0]  wr_addr;
    logic [NWR*32-1:0] wr_data;
    logic           init_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mdl [32];

    reg_file_mp #(
        .NRD (NRD),
        .NWR (NWR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ex0;
        logic [31:0] ex1;
    } vec_t;

    vec_t vt [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic set_wr(input int w, input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en[w]          = en;
        wr_addr[w*5 +: 5] = a;
        wr_data[w*32 +: 32] = d;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr[4:0] = a0;
        rd_addr[9:5] = a1;
    endtask

    function automatic logic [31:0] rd_port(input int p);
        return rd_data[p*32 +: 32];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = (i == RF_SP_IDX) ? RF_SP_INIT : 32'h0;
    endtask

    // Architectural effect of one idle cycle: port 1 applied last so it wins.
    task automatic model_write();
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*5 +: 5] != 5'd0) mdl[wr_addr[w*5 +: 5]] = wr_data[w*32 +: 32];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = mdl[a];
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*5 +: 5] == a) v = wr_data[w*32 +: 32];
        end
        return v;
    endfunction

    task automatic count_busy(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        logic [4:0] a0, a1;

        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        step();
        step();

        // Reset sweep: outputs during INIT, wr_en ignored, exact sweep length
        check("reset_busy", {31'd0, init_busy}, 32'd1);
        rst = 1'b0;
        set_wr(0, 1'b1, 5'd4, 32'h0000_0044);
        set_rd(5'd2, 5'd4);
        #1;
        check("init_rd0_zero", rd_port(0), 32'h0);
        check("init_rd1_nobypass", rd_port(1), 32'h0);
        count_busy(nb);
        check("sweep_len", nb, 32);
        set_wr(0, 1'b0, 5'd0, 32'h0);
        model_reset();
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            #1;
            check("sweep_rd0", rd_port(0), mdl[i]);
            check("sweep_rd1", rd_port(1), mdl[31 - i]);
        end

        // Directed vectors with hand-derived expectations
        vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vt[2]  = '{1'b1, 5'd7,  32'h1234,     1'b0, 5'd0,  32'h0,  5'd7,  5'd7,  32'h1234,     32'h1234};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd7,  5'd2,  32'h1234,     32'h500};
        vt[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,  5'd0,  5'd0,  32'h0,        32'h0};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vt[6]  = '{1'b1, 5'd9,  32'hA,        1'b1, 5'd9,  32'hB,  5'd9,  5'd9,  32'hB,        32'hB};
        vt[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd9,  5'd7,  32'hB,        32'h1234};
        vt[8]  = '{1'b1, 5'd10, 32'h11,       1'b1, 5'd11, 32'h22, 5'd10, 5'd11, 32'h11,       32'h22};
        vt[9]  = '{1'b0, 5'd12, 32'h99,       1'b0, 5'd0,  32'h0,  5'd12, 5'd10, 32'h0,        32'h11};
        vt[10] = '{1'b1, 5'd13, 32'h33,       1'b1, 5'd0,  32'h77, 5'd0,  5'd13, 32'h0,        32'h33};
        vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd13, 5'd12, 32'h33,       32'h0};
        for (int i = 0; i < 12; i++) begin
            set_wr(0, vt[i].we0, vt[i].wa0, vt[i].wd0);
            set_wr(1, vt[i].we1, vt[i].wa1, vt[i].wd1);
            set_rd(vt[i].ra0, vt[i].ra1);
            #1;
            check($sformatf("vec%0d_rd0", i), rd_port(0), vt[i].ex0);
            check($sformatf("vec%0d_rd1", i), rd_port(1), vt[i].ex1);
            model_write();
            step();
        end

        // Randomized traffic against the array model; narrow addresses force collisions
        for (int c = 0; c < 300; c++) begin
            for (int w = 0; w < NWR; w++) begin
                set_wr(w, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
            end
            a0 = 5'($urandom_range(0, 15));
            a1 = (c % 4 == 0) ? a0 : 5'($urandom_range(0, 31));
            set_rd(a0, a1);
            #1;
            check("rand_rd0", rd_port(0), model_read(a0));
            check("rand_rd1", rd_port(1), model_read(a1));
            model_write();
            step();
        end

        // Reset reasserted mid-sweep, with a write to x3 presented alongside
        set_wr(0, 1'b1, 5'd3, 32'h3333);
        set_wr(1, 1'b0, 5'd0, 32'h0);
        step();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_rd(5'd3, 5'd0);
        #1;
        check("pre_x3", rd_port(0), 32'h3333);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        set_rd(5'd2, 5'd3);
        #1;
        check("mid_busy", {31'd0, init_busy}, 32'd1);
        check("mid_rd_zero", rd_port(0), 32'h0);
        rst = 1'b1;
        set_wr(0, 1'b1, 5'd3, 32'hCAFE);
        step();
        rst = 1'b0;
        count_busy(nb);
        check("restart_len", nb, 32);
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_rd(5'd3, 5'd2);
        #1;
        check("restart_x3", rd_port(0), 32'h0);
        check("restart_x2", rd_port(1), 32'h500);
        set_rd(5'd9, 5'd0);
        #1;
        check("restart_x9", rd_port(0), 32'h0);
        check("restart_x0", rd_port(1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
